demux_1_4_reg: RTL and testbench
================================

// Module: demux_1_4_reg
// PURPOSE
//  Registered 1-to-4 demultiplexer: routes one 32-bit valid/ready input stream to one of four
//  output channels selected per transfer by a 2-bit select. Each channel holds a 1-entry
//  output register, giving 1-cycle latency at full throughput.
//  Sits downstream of the datapath result selection and feeds four independent consumers
//  (e.g. register-file write port, memory write, PC load, debug).
// PARAMETERS
//  DATA_W   32   width of data path (in_data, chN_data)
//  CNT_W    16   width of per-channel transfer counters (DEMUX_STATS_EN only)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  in_data    in   DATA_W   input word
//  in_sel     in   2        destination channel 2'b00..2'b11 for in_data
//  in_valid   in   1        input word valid
//  in_ready   out  1        input accepted when in_valid & in_ready at clk edge
//  chN_data   out  DATA_W   channel N data register, N = 0..3
//  chN_valid  out  1        channel N holds a word
//  chN_ready  in   1        channel N consumer accepts when chN_valid & chN_ready
//  chN_count  out  CNT_W    channel N accepted-transfer count (DEMUX_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transfer): all chN_valid=0, chN_data=0, chN_count=0;
//    buffered words are discarded. Outputs are stable from reset assertion, not from next edge.
//  - Per-channel FSM, two states: EMPTY (chN_valid=0) / FULL (chN_valid=1).
//    EMPTY -> FULL : load = in_valid & in_ready & (in_sel==N); chN_data <= in_data.
//    FULL  -> EMPTY: chN_ready & ~load.
//    FULL  -> FULL : load with chN_ready=1 (drain + refill same edge, new data replaces old);
//                    or ~chN_ready (hold data, chN_data must not change).
//  - in_ready = ~chS_valid | chS_ready, where S = in_sel. Combinational from in_sel and the
//    selected channel's state/ready; it must not depend on in_valid.
//  - Latency: word accepted at edge k appears on chN_data/chN_valid after edge k; earliest
//    consumption at edge k+1. One transfer per cycle sustained when consumer ready is held high.
//  - Stalled selected channel (FULL & ~ready) blocks input (in_ready=0) even if other
//    channels are EMPTY; no reordering, no bypass.
//  - Non-selected channels drain independently of input activity.
//  - Consumer handshake rule: once chN_valid=1, data and valid stay stable until chN_ready.
//  - in_sel/in_data ignored when in_valid=0; X on in_sel with in_valid=0 must not corrupt state.
// CONFIGURATION
//  DEMUX_STATS_EN defined: chN_count increments by 1 on each load into channel N, wraps
//    2^CNT_W-1 -> 0, cleared only by rst. Counters change no handshake or data behaviour.
//  DEMUX_STATS_EN undefined: chN_count ports and counter logic absent; rest identical.
// TESTING
//  1 rst=1 mid-run with ch2 FULL (data 32'hDEADBEEF) -> ch0..3_valid=0 and data=0
//    immediately, before any clock edge.
//  2 in_sel=2'b01, in_data=32'h0000_00A5, valid 1 cycle, ch1_ready=1 -> ch1_valid=1 with
//    data A5 for exactly 1 cycle after the edge; other channels stay valid=0.
//  3 ch3_ready=0, send 32'h11 then 32'h22 to ch3 -> first accepted; in_ready=0 for second;
//    ch3 holds 32'h11; raise ch3_ready -> 32'h22 accepted on the same edge 32'h11 drains.
//  4 Back-to-back 8 words to sel 0,1,2,3,0,1,2,3, all readies=1 -> in_ready=1 every cycle;
//    each channel outputs its 2 words in order, 1-cycle latency.
//  5 ch0 FULL and stalled, in_sel=2'b10 -> in_ready=1, ch2 loads; then in_sel=2'b00 ->
//    in_ready=0 until ch0_ready=1.
//  6 DEMUX_STATS_EN, CNT_W=4: 17 loads into ch1 -> ch1_count=4'd1 (wrap); others 0;
//    rebuild without macro -> tests 1-5 pass unchanged.

Source files
------------

// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer for a valid/ready stream.
// Each output channel has a one-entry register, so a word appears one cycle after it is
// accepted, and each channel sustains one transfer per cycle.
// Optional build macro DEMUX_STATS_EN adds a wrapping per-channel count of accepted loads
// (chN_count). When it is undefined, those ports and counters do not exist.
module demux_1_4_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] ch0_data,
    output logic              ch0_valid,
    input  logic              ch0_ready,
    output logic [DATA_W-1:0] ch1_data,
    output logic              ch1_valid,
    input  logic              ch1_ready,
    output logic [DATA_W-1:0] ch2_data,
    output logic              ch2_valid,
    input  logic              ch2_ready,
    output logic [DATA_W-1:0] ch3_data,
    output logic              ch3_valid,
    input  logic              ch3_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  ch0_count,
    output logic [CNT_W-1:0]  ch1_count,
    output logic [CNT_W-1:0]  ch2_count,
    output logic [CNT_W-1:0]  ch3_count
`endif
);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } ch_state_e;

    ch_state_e         state_q [4];
    logic [DATA_W-1:0] data_q  [4];
    logic [3:0]        ch_valid;
    logic [3:0]        ch_ready;
    logic [3:0]        load;

    assign ch_ready = {ch3_ready, ch2_ready, ch1_ready, ch0_ready};

    // Channel register views onto the output ports.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ch_valid[n] = (state_q[n] == StFull);
        end
    end

    assign ch0_data  = data_q[0];
    assign ch1_data  = data_q[1];
    assign ch2_data  = data_q[2];
    assign ch3_data  = data_q[3];
    assign ch0_valid = ch_valid[0];
    assign ch1_valid = ch_valid[1];
    assign ch2_valid = ch_valid[2];
    assign ch3_valid = ch_valid[3];

    // Input ready follows only the selected channel; a stalled target blocks the stream
    // even when other channels are free, which keeps words in order.
    always_comb begin
        in_ready = ~ch_valid[in_sel] | ch_ready[in_sel];
    end

    // Load strobes; in_valid gates everything, so an unknown in_sel while idle loads nothing.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            load[n] = in_valid & in_ready & (in_sel == 2'(n));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        // Per-channel EMPTY/FULL state machine with its data register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q[g] <= StEmpty;
                data_q[g]  <= '0;
            end else begin
                unique case (state_q[g])
                    StEmpty: begin
                        if (load[g]) begin
                            state_q[g] <= StFull;
                            data_q[g]  <= in_data;
                        end
                    end
                    StFull: begin
                        // A load here implies the consumer drained the old word on this edge.
                        if (load[g]) begin
                            data_q[g] <= in_data;
                        end else if (ch_ready[g]) begin
                            state_q[g] <= StEmpty;
                        end
                    end
                    default: begin
                        state_q[g] <= StEmpty;
                    end
                endcase
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        // Accepted-load counter; wraps naturally at its width.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[g] <= '0;
            end else if (load[g]) begin
                cnt_q[g] <= cnt_q[g] + CNT_W'(1);
            end
        end
    end

    assign ch0_count = cnt_q[0];
    assign ch1_count = cnt_q[1];
    assign ch2_count = cnt_q[2];
    assign ch3_count = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Scoreboard bench for demux_1_4_reg: the driver pushes expected words per channel,
// a negedge monitor pops and compares on each consumer handshake.
module tb_demux_1_4_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic          ch0_valid, ch1_valid, ch2_valid, ch3_valid;
    logic          ch0_ready, ch1_ready, ch2_ready, ch3_ready;
`ifdef DEMUX_STATS_EN
    logic [CW-1:0] ch0_count, ch1_count, ch2_count, ch3_count;
`endif

    demux_1_4_reg #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch0_data  (ch0_data),
        .ch0_valid (ch0_valid),
        .ch0_ready (ch0_ready),
        .ch1_data  (ch1_data),
        .ch1_valid (ch1_valid),
        .ch1_ready (ch1_ready),
        .ch2_data  (ch2_data),
        .ch2_valid (ch2_valid),
        .ch2_ready (ch2_ready),
        .ch3_data  (ch3_data),
        .ch3_valid (ch3_valid),
        .ch3_ready (ch3_ready)
`ifdef DEMUX_STATS_EN
        ,
        .ch0_count (ch0_count),
        .ch1_count (ch1_count),
        .ch2_count (ch2_count),
        .ch3_count (ch3_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q [4][$];
    logic [3:0]    v;
    logic [3:0]    r;
    logic [DW-1:0] d [4];
    logic [3:0]    held;
    logic [DW-1:0] held_d [4];

    assign v    = {ch3_valid, ch2_valid, ch1_valid, ch0_valid};
    assign r    = {ch3_ready, ch2_ready, ch1_ready, ch0_ready};
    assign d[0] = ch0_data;
    assign d[1] = ch1_data;
    assign d[2] = ch2_data;
    assign d[3] = ch3_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumer handshakes pop the scoreboard; stalled words must stay put.
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (v[n]) begin
                    if (held[n]) chk($sformatf("ch%0d_hold", n), d[n], held_d[n]);
                    if (r[n]) begin
                        held[n] = 1'b0;
                        if (exp_q[n].size() == 0) begin
                            chk($sformatf("ch%0d_unexpected", n), d[n], 64'hdead_0000);
                        end else begin
                            chk($sformatf("ch%0d_data", n), d[n], exp_q[n].pop_front());
                        end
                    end else begin
                        held[n]   = 1'b1;
                        held_d[n] = d[n];
                    end
                end else if (held[n]) begin
                    chk($sformatf("ch%0d_valid_dropped", n), 0, 1);
                    held[n] = 1'b0;
                end
            end
        end
    end

    // One-cycle offer of a word; exp_rdy is the hand-derived in_ready for that cycle.
    task automatic send(input logic [1:0] sel, input logic [DW-1:0] dat, input bit exp_rdy);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = dat;
        @(negedge clk);
        chk($sformatf("in_ready_sel%0d", sel), in_ready, exp_rdy);
        if (exp_rdy) exp_q[sel].push_back(dat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sel   = 2'bxx;
    endtask

    // Offer held through a stall; consumer of sel is released after 2 blocked cycles.
    task automatic send_stalled(input logic [1:0] sel, input logic [DW-1:0] dat);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = dat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stall_in_ready_sel%0d", sel), in_ready, 0);
            @(posedge clk);
            #1;
        end
        case (sel)
            2'd0: ch0_ready = 1'b1;
            2'd1: ch1_ready = 1'b1;
            2'd2: ch2_ready = 1'b1;
            default: ch3_ready = 1'b1;
        endcase
        @(negedge clk);
        chk($sformatf("release_in_ready_sel%0d", sel), in_ready, 1);
        exp_q[sel].push_back(dat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sel   = 2'bxx;
    endtask

    task automatic clear_sb();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
    endtask

    initial begin
        logic [1:0] prev;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        {ch3_ready, ch2_ready, ch1_ready, ch0_ready} = 4'hf;
        held      = '0;
        #1;
        chk("reset_valids", v, 4'h0);
        chk("reset_ch0_data", ch0_data, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;

        // Single word to ch1, visible for exactly one cycle.
        send(2'd1, 32'h0000_00A5, 1'b1);
        @(negedge clk);
        chk("t2_ch1_valid", ch1_valid, 1);
        chk("t2_ch1_data", ch1_data, 32'hA5);
        chk("t2_others_idle", v & 4'b1101, 4'h0);
        @(negedge clk);
        chk("t2_ch1_gone", ch1_valid, 0);
        @(posedge clk);
        #1;

        // ch3 stalled: second word waits, then refill on the draining edge.
        ch3_ready = 1'b0;
        send(2'd3, 32'h11, 1'b1);
        #1;
        chk("t3_ch3_holds", ch3_data, 32'h11);
        send_stalled(2'd3, 32'h22);
        @(negedge clk);
        chk("t3_ch3_refilled", ch3_data, 32'h22);
        @(posedge clk);
        #1;

        // Back-to-back round robin at full rate with one-cycle latency.
        prev = 2'd0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i % 4);
            in_data  = 32'h100 + 32'(i);
            @(negedge clk);
            chk("t4_in_ready", in_ready, 1);
            exp_q[in_sel].push_back(in_data);
            if (i > 0) chk("t4_latency", v[prev], 1);
            prev = in_sel;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_last_latency", v[prev], 1);
        @(posedge clk);
        #1;

        // ch0 stalled does not block ch2, but blocks further ch0 traffic.
        ch0_ready = 1'b0;
        send(2'd0, 32'h50, 1'b1);
        send(2'd2, 32'h52, 1'b1);
        send_stalled(2'd0, 32'h60);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while ch2 holds a word.
        ch2_ready = 1'b0;
        send(2'd2, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("t1_ch2_full", ch2_data, 32'hDEADBEEF);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t1_valids_async", v, 4'h0);
        chk("t1_ch2_data_async", ch2_data, 0);
        chk("t1_ch0_data_async", ch0_data, 0);
        clear_sb();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        ch2_ready = 1'b1;
        #1;

`ifdef DEMUX_STATS_EN
        // 17 loads into a 4-bit counter wrap to 1.
        chk("t6_count_reset", {ch3_count, ch2_count, ch1_count, ch0_count}, 16'h0);
        for (int i = 0; i < 17; i++) send(2'd1, 32'h200 + 32'(i), 1'b1);
        @(negedge clk);
        chk("t6_ch1_count", ch1_count, 4'd1);
        chk("t6_other_counts", {ch3_count, ch2_count, ch0_count}, 12'h0);
        @(posedge clk);
        #1;
`endif

        // Drain everything, bounded.
        {ch3_ready, ch2_ready, ch1_ready, ch0_ready} = 4'hf;
        for (int i = 0; i < 20; i++) begin
            if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) == 0)
                break;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("final_q%0d_empty", n), exp_q[n].size(), 0);
        end
        chk("final_valids", v, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
